req_array_arbiter: RTL and testbench
====================================

// Module: req_array_arbiter
// PURPOSE
//   Round-robin arbiter that merges an array of N valid/ready request channels
//   (one per element of an interface array) into a single registered output
//   channel consumed by the single-interface stage downstream. One transfer per
//   cycle at full throughput; output is held stable while stalled.
// PARAMETERS
//   N  4  number of request channels (interface array depth), N >= 2
//   W  8  data width per channel
// PORTS
//   clk        input   1          clock, all state on rising edge
//   rst        input   1          reset, asynchronous, active-high
//   req_valid  input   N          per-channel request valid
//   req_data   input   N*W        channel i data at [i*W +: W]
//   req_ready  output  N          per-channel accept (one-hot or zero)
//   out_valid  output  1          registered output valid
//   out_data   output  W          registered output data
//   out_src    output  $clog2(N)  index of channel that produced out_data
//   out_ready  input   1          downstream accept
// BEHAVIOUR
//   Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, ptr=0 (channel 0
//     highest priority). req_ready=0 while rst asserted. Mid-transfer reset drops
//     the held word; no channel sees a handshake in the reset cycle.
//   load = !out_valid || out_ready (output register empty or draining this cycle).
//   Grant (combinational): first i with req_valid[i]=1 searching ptr, ptr+1, ...,
//     N-1, 0, ..., ptr-1 (modulo-N wrap). gnt_any = |req_valid.
//   req_ready[i] = load && gnt_any && (i == grant); at most one bit set.
//     req_ready never depends on req_data; depends on req_valid and out_ready.
//   Transfer in: req_valid[g] && req_ready[g] -> next edge out_valid=1,
//     out_data=req_data[g], out_src=g, ptr=(g+1) mod N. Latency 1 cycle.
//   Transfer out: out_valid && out_ready. If no new request that cycle, next
//     edge out_valid=0; out_data/out_src keep last value.
//   Simultaneous out+in in one cycle: output replaced with new word, out_valid
//     stays 1 (back-to-back, no bubble).
//   Stall (out_valid && !out_ready): out_valid/out_data/out_src held; req_ready=0;
//     ptr unchanged.
//   ptr advances only on an accepted input transfer; idle cycles do not move it.
//   Wrap: grant N-1 sets ptr=0; ptr width $clog2(N), N not a power of two must
//     wrap explicitly at N-1 (never reaches N).
//   Requests may drop valid while not granted; no fairness credit retained.
//   States (2): EMPTY (out_valid=0) -> FULL on any input transfer; FULL -> EMPTY
//     on output transfer with no input transfer; FULL -> FULL otherwise.
// TESTING
//   1 rst=1 then release, no requests -> out_valid=0, req_ready=0, out_src=0.
//   2 req_valid=4'b1111, out_ready=1 constant, data i=8'hA0+i -> out_src sequence
//     0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0, out_valid stays 1.
//   3 only channel 2 valid (data 8'h5C), out_ready=0 for 3 cycles -> out_data=5C
//     held, req_ready=0 during stall; out_ready=1 -> next grant is channel 2 again.
//   4 ptr=3 (after grant 2), req_valid=4'b0101 -> grant 0 (wrap), ptr becomes 1,
//     then grant 2 next.
//   5 N=3: req_valid=3'b111 continuously -> out_src 0,1,2,0,1; ptr never equals 3.
//   6 rst asserted while out_valid=1 && out_ready=0 -> out_valid=0 immediately
//     (before next edge), ptr=0; after release first grant is lowest valid index.

Source files
------------

// File: rtl/req_array_arbiter_if.sv
// Handshake bundle for req_array_arbiter: N request channels in, one registered channel out.
// The requester side (master) drives req_valid/req_data/out_ready; the arbiter (slave) drives the rest.
interface req_array_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/req_array_arbiter.sv
// Round-robin merge of N valid/ready channels into one registered output; 1-cycle latency.
// Accepts a new word whenever the output register is empty or draining; holds output stable under stall.
module req_array_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic                clk,
  input logic                rst,
  req_array_arbiter_if.slave bus
);
  localparam int SW = $clog2(N);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state;
  logic [SW-1:0] ptr;
  logic [W-1:0]  data_q;
  logic [SW-1:0] src_q;

  logic [SW-1:0] grant;
  logic [SW-1:0] idx;
  logic          found;
  logic          gnt_any;
  logic          load;
  logic          take;
  logic [W-1:0]  sel_data;

  // Walk the channels starting at ptr with explicit wrap so non-power-of-two N never indexes past N-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
      idx = (idx == SW'(N - 1)) ? '0 : idx + SW'(1);
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == SW'(k)) sel_data = bus.req_data[k*W +: W];
    end
  end

  assign gnt_any = |bus.req_valid;
  assign load    = (state == EMPTY) || bus.out_ready;
  // Gated by rst so no channel observes a handshake during the reset cycle.
  assign take    = load && gnt_any && !rst;

  assign bus.req_ready = take ? (N'(1) << grant) : '0;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      ptr    <= '0;
      data_q <= '0;
      src_q  <= '0;
    end else begin
      if (take) begin
        data_q <= sel_data;
        src_q  <= grant;
        ptr    <= (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
      end
      case (state)
        EMPTY: if (take) state <= FULL;
        FULL:  if (bus.out_ready && !take) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_ptr_range:    assert property (@(posedge clk) disable iff (rst) int'(ptr) < N);
endmodule

// File: tb/tb_req_array_arbiter.sv
// Directed bench for req_array_arbiter: N=4 instance for most scenarios, N=3 instance for the odd wrap.
module tb_req_array_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  req_array_arbiter_if #(.N(4), .W(8)) if4 ();
  req_array_arbiter_if #(.N(3), .W(8)) if3 ();

  req_array_arbiter #(.N(4), .W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  req_array_arbiter #(.N(3), .W(8)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  int t2_src[5]   = '{0, 1, 2, 3, 0};
  int t2_dat[5]   = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA0};
  int t2_rdy[5]   = '{1, 2, 4, 8, 1};
  int t5_src[5]   = '{0, 1, 2, 0, 1};
  int t5_dat[5]   = '{'hC0, 'hC1, 'hC2, 'hC0, 'hC1};
  int t5_rdy[5]   = '{1, 2, 4, 1, 2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out4(input string tag, input int v, input int d, input int s);
    chk({tag, "_valid"}, 32'(if4.out_valid), v);
    chk({tag, "_data"},  32'(if4.out_data),  d);
    chk({tag, "_src"},   32'(if4.out_src),   s);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if4.req_valid = '0; if4.req_data = '0; if4.out_ready = 1'b0;
    if3.req_valid = '0; if3.req_data = '0; if3.out_ready = 1'b0;

    // 1: reset state, and no handshake offered while rst is high
    repeat (2) cyc();
    if4.req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 32'(if4.req_ready), 0);
    chk_out4("rst", 0, 0, 0);
    if4.req_valid = '0;
    rst = 1'b0;
    #1;
    chk("t1_req_ready", 32'(if4.req_ready), 0);
    chk_out4("t1", 0, 0, 0);
    cyc();
    chk("t1_idle_valid", 32'(if4.out_valid), 0);

    // 2: all channels valid, full throughput rotation
    if4.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    if4.req_valid = 4'b1111;
    if4.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_req_ready", 32'(if4.req_ready), t2_rdy[i]);
      cyc();
      chk_out4("t2", 1, t2_dat[i], t2_src[i]);
    end
    if4.req_valid = '0;
    #1;
    chk("t2_drain_ready", 32'(if4.req_ready), 0);
    cyc();
    chk_out4("t2_drain", 0, 'hA0, 0);

    // 3: single requester with a 3-cycle downstream stall (ptr=1 here)
    if4.req_data  = {8'h00, 8'h5C, 8'h00, 8'h00};
    if4.req_valid = 4'b0100;
    if4.out_ready = 1'b0;
    #1;
    chk("t3_first_ready", 32'(if4.req_ready), 4);
    cyc();
    chk_out4("t3_load", 1, 'h5C, 2);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall_ready", 32'(if4.req_ready), 0);
      cyc();
      chk_out4("t3_stall", 1, 'h5C, 2);
    end
    if4.out_ready = 1'b1;
    #1;
    chk("t3_release_ready", 32'(if4.req_ready), 4);
    cyc();
    chk_out4("t3_release", 1, 'h5C, 2);

    // 4: ptr=3, channels 0 and 2 -> wrap to 0, then 2, then 0
    if4.req_data  = {8'h00, 8'h22, 8'h00, 8'h11};
    if4.req_valid = 4'b0101;
    #1;
    chk("t4_wrap_ready", 32'(if4.req_ready), 1);
    cyc();
    chk_out4("t4_wrap", 1, 'h11, 0);
    #1;
    chk("t4_next_ready", 32'(if4.req_ready), 4);
    cyc();
    chk_out4("t4_next", 1, 'h22, 2);
    #1;
    chk("t4_again_ready", 32'(if4.req_ready), 1);
    cyc();
    chk_out4("t4_again", 1, 'h11, 0);
    if4.req_valid = '0;
    cyc();
    chk("t4_drain_valid", 32'(if4.out_valid), 0);

    // 5: N=3 wraps at 2 back to 0
    if3.req_data  = {8'hC2, 8'hC1, 8'hC0};
    if3.req_valid = 3'b111;
    if3.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_req_ready", 32'(if3.req_ready), t5_rdy[i]);
      cyc();
      chk("t5_src",   32'(if3.out_src),   t5_src[i]);
      chk("t5_data",  32'(if3.out_data),  t5_dat[i]);
      chk("t5_valid", 32'(if3.out_valid), 1);
    end
    if3.req_valid = '0;

    // 6: reset while stalled with a held word (ptr=1 going in)
    if4.req_data  = {8'h00, 8'h00, 8'h77, 8'h00};
    if4.req_valid = 4'b0010;
    if4.out_ready = 1'b0;
    #1;
    chk("t6_load_ready", 32'(if4.req_ready), 2);
    cyc();
    chk_out4("t6_held", 1, 'h77, 1);
    #1;
    chk("t6_stall_ready", 32'(if4.req_ready), 0);
    rst = 1'b1;
    #1;
    chk_out4("t6_async", 0, 0, 0);
    chk("t6_rst_ready", 32'(if4.req_ready), 0);
    if4.req_data  = {8'h88, 8'h00, 8'h77, 8'h00};
    if4.req_valid = 4'b1010;
    cyc();
    rst = 1'b0;
    if4.out_ready = 1'b1;
    #1;
    chk("t6_post_ready", 32'(if4.req_ready), 2);
    cyc();
    chk_out4("t6_post", 1, 'h77, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
